fun_root_mul: RTL

Parametrised successor to the team's fixed 8-bit `a * cbrt(b)` unit. It computes `y = a * floor(root_k(b))`, where the root order k (square or cube) is selected per operation. Operand width is a parameter. Completion is flagged by a dedicated one-cycle pulse. The block sits on the same start/busy handshake used by the rest of the lab datapath and is a drop-in replacement when `WIDTH=8` and `mode_i=1`.

---
 rtl/fun_pkg.sv | 19 +
 rtl/root_trial.sv | 29 ++
 rtl/fun_root_mul.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fun_pkg.sv
// Shared definitions for the root-multiply datapath: mode codes, FSM states
// and the root-bit count helper.
package fun_pkg;

  localparam logic MODE_SQRT = 1'b0;
  localparam logic MODE_CBRT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROOT = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  // Number of integer-root bits needed for a WIDTH-bit radicand.
  function automatic int unsigned root_bits(input int unsigned width, input logic mode);
    return (mode == MODE_CBRT) ? (width + 2) / 3 : (width + 1) / 2;
  endfunction

endpackage

// File: rtl/root_trial.sv
// Combinational trial compare for the digit-by-digit root: fit_c = (t^k <= b).
// The power is formed at 3*WIDTH bits so a cube never truncates.
module root_trial
  import fun_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] t_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mode_i,
  output logic             fit_c
);

  localparam int unsigned PW = 3 * WIDTH;

  logic [PW-1:0] t_ext;
  logic [PW-1:0] sq;
  logic [PW-1:0] cube;
  logic [PW-1:0] pw;

  always_comb begin
    t_ext = PW'(t_i);
    sq    = t_ext * t_ext;
    cube  = sq * t_ext;
    pw    = (mode_i == MODE_CBRT) ? cube : sq;
    fit_c = (pw <= PW'(b_i));
  end

endmodule

// File: rtl/fun_root_mul.sv
// y = a * floor(root_k(b)), k = 2 or 3 per operation: bitwise root search
// (MSB first) followed by a shift-add multiply over the root bits (LSB first).
module fun_root_mul
  import fun_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   y_bo,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned YW     = 2 * WIDTH;
  localparam int unsigned CW     = $clog2(WIDTH + 1);
  localparam int unsigned R_SQRT = root_bits(WIDTH, MODE_SQRT);
  localparam int unsigned R_CBRT = root_bits(WIDTH, MODE_CBRT);

  state_e state_q, state_d;

  logic             mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [YW-1:0]    p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [YW-1:0]    y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] trial_c;
  logic [WIDTH-1:0] r_shift_c;
  logic [CW-1:0]    first_idx_c;
  logic [CW-1:0]    last_idx_c;
  logic             fit_c;

  // Root-bit count depends on the mode: the incoming one on accept, the latched one afterwards.
  always_comb begin
    first_idx_c = (mode_i == MODE_CBRT) ? CW'(R_CBRT - 1) : CW'(R_SQRT - 1);
    last_idx_c  = (mode_q == MODE_CBRT) ? CW'(R_CBRT - 1) : CW'(R_SQRT - 1);
    trial_c     = r_q | (WIDTH'(1) << cnt_q);
    r_shift_c   = r_q >> cnt_q;
  end

  root_trial #(
    .WIDTH (WIDTH)
  ) u_root_trial (
    .t_i    (trial_c),
    .b_i    (b_q),
    .mode_i (mode_q),
    .fit_c  (fit_c)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_ROOT;
      ST_ROOT: if (cnt_q == '0) state_d = ST_MUL;
      ST_MUL:  if (cnt_q == last_idx_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    mode_d = mode_q;
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    y_d    = y_q;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d = mode_i;
          a_d    = a_i;
          b_d    = b_i;
          r_d    = '0;
          p_d    = '0;
          cnt_d  = first_idx_c;
        end
      end
      ST_ROOT: begin
        if (fit_c) r_d = trial_c;
        // Counter lands on 0 so the multiply starts at the root LSB.
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      ST_MUL: begin
        if (r_shift_c[0]) p_d = p_q + (YW'(a_q) << cnt_q);
        if (cnt_q == last_idx_c) begin
          y_d    = p_d;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= MODE_SQRT;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign y_bo   = y_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
